// File: rtl/keystream_xor_pkg.sv
// Shared types and constants for the ChaCha20 keystream XOR stage.
package keystream_xor_pkg;

  localparam int BYTE_W   = 8;
  localparam int KS_BYTES = 64;

  typedef logic [31:0]       word_t;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } xor_state_t;

  // Index width that stays legal for a single-entry buffer.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keystream_xor_if.sv
// Keystream, plaintext and ciphertext signals of the keystream XOR stage.
interface keystream_xor_if #(
  parameter int DATA_SIZE = 8,
  parameter int NO_REG    = 64,
  parameter int CNT_W     = 32
);

  logic [DATA_SIZE-1:0] ks_block [0:NO_REG-1];
  logic                 ks_full;
  logic                 ks_consume;
  logic                 ks_req;

  logic [DATA_SIZE-1:0] pt_data;
  logic                 pt_valid;
  logic                 pt_last;
  logic                 pt_ready;

  logic [DATA_SIZE-1:0] ct_data;
  logic                 ct_valid;
  logic                 ct_last;
  logic                 ct_ready;

  logic [CNT_W-1:0]     blk_cnt;

  modport master (
    output ks_block, ks_full, pt_data, pt_valid, pt_last, ct_ready,
    input  ks_consume, ks_req, pt_ready, ct_data, ct_valid, ct_last, blk_cnt
  );

  modport slave (
    input  ks_block, ks_full, pt_data, pt_valid, pt_last, ct_ready,
    output ks_consume, ks_req, pt_ready, ct_data, ct_valid, ct_last, blk_cnt
  );

endinterface

// File: rtl/keystream_xor_buf.sv
// Keystream block register file: whole-block parallel load, one indexed byte read.
module ks_byte_buffer #(
  parameter int DATA_SIZE = 8,
  parameter int NO_REG    = 64,
  parameter int IDX_W     = 6
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] load_data [0:NO_REG-1],
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem_reg [0:NO_REG-1];

  // Contents are meaningless until the first load, so no reset is needed.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NO_REG; i++) begin
        mem_reg[i] <= load_data[i];
      end
    end
  end

  assign rd_data = mem_reg[rd_idx];

endmodule

// File: rtl/keystream_xor.sv
// Captures one keystream block, then XORs plaintext bytes into a registered
// ciphertext stream; each message starts on a fresh block.
module keystream_xor
  import keystream_xor_pkg::*;
#(
  parameter int DATA_SIZE = BYTE_W,
  parameter int NO_REG    = KS_BYTES,
  parameter int CNT_W     = 32
) (
  input logic            clk,
  input logic            rst,
  keystream_xor_if.slave bus
);

  localparam int               IDX_W    = idx_width(NO_REG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_REG - 1);

  xor_state_t           state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg;
  logic [DATA_SIZE-1:0] ks_byte;
  logic [DATA_SIZE-1:0] ct_data_reg;
  logic                 ct_valid_reg;
  logic                 ct_last_reg;
  logic                 ks_consume_reg;
  logic [CNT_W-1:0]     blk_cnt_reg;

  logic capture;
  logic pt_ready_int;
  logic ks_req_int;
  logic accept;
  logic block_done;

  ks_byte_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .NO_REG    (NO_REG),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk       (clk),
    .load      (capture),
    .load_data (bus.ks_block),
    .rd_idx    (idx_reg),
    .rd_data   (ks_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (bus.ks_full) state_next = ACTIVE;
      ACTIVE:  if (block_done)  state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // ks_full is only looked at while EMPTY, so a block can never be overwritten mid-use.
  always_comb begin
    capture      = 1'b0;
    pt_ready_int = 1'b0;
    ks_req_int   = 1'b0;
    case (state_reg)
      EMPTY: begin
        ks_req_int = 1'b1;
        capture    = bus.ks_full;
      end
      ACTIVE:  pt_ready_int = !ct_valid_reg || bus.ct_ready;
      default: ;
    endcase
  end

  assign accept     = pt_ready_int && bus.pt_valid;
  assign block_done = accept && ((idx_reg == LAST_IDX) || bus.pt_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg        <= '0;
      ks_consume_reg <= 1'b0;
      blk_cnt_reg    <= '0;
      ct_data_reg    <= '0;
      ct_valid_reg   <= 1'b0;
      ct_last_reg    <= 1'b0;
    end else begin
      ks_consume_reg <= capture;
      if (capture) begin
        blk_cnt_reg <= blk_cnt_reg + CNT_W'(1);
      end

      if (capture || block_done) begin
        idx_reg <= '0;
      end else if (accept) begin
        idx_reg <= idx_reg + IDX_W'(1);
      end

      if (accept) begin
        ct_data_reg  <= bus.pt_data ^ ks_byte;
        ct_valid_reg <= 1'b1;
        ct_last_reg  <= bus.pt_last;
      end else if (bus.ct_ready) begin
        ct_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.ks_consume = ks_consume_reg;
  assign bus.ks_req     = ks_req_int;
  assign bus.pt_ready   = pt_ready_int;
  assign bus.ct_data    = ct_data_reg;
  assign bus.ct_valid   = ct_valid_reg;
  assign bus.ct_last    = ct_last_reg;
  assign bus.blk_cnt    = blk_cnt_reg;

endmodule
